// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter blocks: state encoding and default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } state_e;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter / interval timer. Counts a loaded value down to
// terminal count, then either stops with a sticky expired flag (one-shot)
// or reloads for periodic ticks (auto mode). Never wraps below zero.
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENA,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA,
  input  logic             AUTO,
  input  logic             ACK,
  output logic [WIDTH-1:0] CNT,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  // Next-state logic: hold when disabled, then load > ack > count.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (ENA) begin
      if (LOAD) begin
        // A load restarts the count from any state; a zero load parks in IDLE.
        cnt_d    = DATA;
        reload_d = DATA;
        state_d  = (DATA != ZERO) ? ST_RUN : ST_IDLE;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            if (cnt_q > ONE) begin
              cnt_d = cnt_q - ONE;
            end else if (cnt_q == ONE) begin
              tc_d = 1'b1;
              // AUTO only matters here; a zero reload value cannot recycle.
              if (AUTO && (reload_q != ZERO)) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = ZERO;
                state_d = ST_EXPIRED;
              end
            end
          end
          ST_EXPIRED: begin
            if (ACK) state_d = ST_IDLE;
          end
          ST_IDLE: begin
            // Count and ACK are ignored while idle.
          end
          default: begin
            // Unused encoding: recover to a safe, quiet state.
            state_d = ST_IDLE;
            cnt_d   = ZERO;
          end
        endcase
      end
    end
  end

  // State, count, reload and TC registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= ZERO;
      reload_q <= ZERO;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign CNT  = cnt_q;
  assign TC   = tc_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_EXPIRED);

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable, programmable down-counter and interval timer, the count-down complement to the team's 8-bit loadable up-counter. It loads a start value, decrements once per enabled clock, and flags terminal count. It then either stops with a sticky expired flag or auto-reloads for periodic ticks. It sits beside the up-counter in the lab datapath as the timeout/interval generator.

## Interface
Parameters:
- WIDTH, 8, count and data width in bits

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RST  input  1  reset, synchronous and active-high; highest priority
- ENA  input  1  enable; when low, all state (including LOAD) is held
- LOAD  input  1  parallel load of DATA; qualified by ENA
- DATA  input  WIDTH  start/reload value
- AUTO  input  1  1 = auto-reload at terminal count; 0 = one-shot
- ACK  input  1  clears the sticky EXPIRED condition; qualified by ENA
- CNT  output  WIDTH  current count, registered
- TC  output  1  terminal-count pulse, registered, exactly one cycle
- BUSY  output  1  high while state is RUN
- DONE  output  1  sticky expired flag; high while state is EXPIRED

## Operation
- Internal RELOAD register (WIDTH bits) captures DATA on every accepted load.
- Priority on each edge: RST > !ENA (hold) > LOAD > ACK > count.
- RST=1: CNT=0, RELOAD=0, TC=0, state IDLE, so BUSY=0 and DONE=0. Applies in any state, mid-count included.
- ENA=0: CNT, RELOAD, and state are held. TC is 0 in the following cycle.
- LOAD accepted (ENA=1): CNT<=DATA, RELOAD<=DATA, TC<=0. State goes to RUN if DATA!=0, else IDLE. A load from any state, including RUN and EXPIRED, restarts the count.
- State IDLE: CNT holds its value. ACK and count are ignored.
- State RUN, no load:
  - If CNT>1: CNT<=CNT-1.
  - If CNT==1: TC<=1. If AUTO=1 and RELOAD!=0, CNT<=RELOAD and the state stays RUN. Otherwise CNT<=0 and the state goes to EXPIRED.
- State EXPIRED: CNT holds 0. ACK=1 (ENA=1, no LOAD) moves the state to IDLE. LOAD moves to RUN/IDLE as above.
- No underflow: CNT never wraps from 0 to 2^WIDTH-1 in any state, unlike the up-counter rollover.
- AUTO is sampled only at the CNT==1 edge. Changing it mid-count has no other effect.
- All arithmetic is unsigned WIDTH bits. The decrement is computed only when CNT>=1.

## Timing
- Load latency: 1 cycle, so CNT=DATA is visible in the cycle after LOAD is sampled.
- One-shot: with load value N and ENA continuously high, TC and DONE first read 1 exactly N cycles after the load edge, in the same cycle CNT first reads 0.
- Auto-reload: TC pulses every N enabled cycles. CNT sequence is N, N-1 … 1, N … with no 0 state.
- ENA low for k cycles stretches any interval by exactly k cycles.
- TC is high for exactly one cycle per expiry. It is never high two cycles in a row unless N==1 in auto mode, where it is continuously high.
- Simultaneous LOAD with CNT==1 in RUN: the load wins and TC stays 0.
- Simultaneous LOAD and ACK in EXPIRED: the load wins.

## Structure
- Shared package counter_pkg holds:
  - state encoding constants: ST_IDLE=2'b00, ST_RUN=2'b01, ST_EXPIRED=2'b10
  - the default WIDTH (8)
- The up-counter testbench and this block both use counter_pkg.
- Single module: one state register, the CNT/RELOAD registers, and the registered TC. No sub-module is warranted.
- BUSY and DONE are decoded directly from the state register.

## Test plan
- Reset: RST=1 mid-count at CNT=5 → next edge CNT=0, state IDLE, TC/BUSY/DONE=0; RST overrides a simultaneous LOAD of 8'd250.
- One-shot: load 8'd8 with AUTO=0 → CNT 8…1 then 0 on the 8th cycle, TC=1 for one cycle, DONE=1 held; ACK → DONE=0, CNT stays 0.
- Auto-reload: load 8'd3 with AUTO=1 → CNT 3,2,1,3,2,1…; TC pulses every 3 cycles; DONE never set.
- Enable gating: ENA=0 for 2 cycles while CNT=5, with LOAD=1 and DATA=8'd200 → CNT stays 5 and no load occurs; on re-enable, the count resumes and the TC interval is extended by 2 cycles.
- Boundaries: load 8'd0 → IDLE with CNT=0, no TC, no wrap to 255; LOAD with DATA=8'd10 coincident with CNT==1 → CNT=10, TC=0.
- Width check: WIDTH=4, load 4'd15 with AUTO=1 → period 15, CNT never exceeds 15 and never shows 0.
